// File: rtl/bp_update_scheduler.sv
// Arbitrates two branch-resolve slots into a small FIFO that drains one
// update per cycle into the bimodal predictor's single update port.
module bp_update_scheduler #(
    parameter int INDEX_BITS = 10,
    parameter int DEPTH      = 4,
    localparam int PW        = $clog2(DEPTH),
    localparam int CW        = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [31:0]   req0_pc,
    input  logic          req0_taken,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [31:0]   req1_pc,
    input  logic          req1_taken,
    input  logic          flush,
    output logic          upd_en,
    output logic [31:0]   upd_pc,
    output logic          upd_taken,
    input  logic [31:0]   lookup_pc,
    output logic          pend_hit,
    output logic [CW-1:0] count
);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   pc_q    [DEPTH];
    logic [31:0]   pc_d    [DEPTH];
    logic          taken_q [DEPTH];
    logic          taken_d [DEPTH];
    logic          vld_q   [DEPTH];
    logic          vld_d   [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rr_q, rr_d;

    logic [CW-1:0] free;
    logic          acc0, acc1;
    logic [PW-1:0] wr_idx1;

    assign free = DEPTH_C - count_q;

    // With one free slot, a lone requester wins; a contended slot goes to rr.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!flush) begin
            if (free >= CW'(2)) begin
                req0_ready = 1'b1;
                req1_ready = 1'b1;
            end else if (free == CW'(1)) begin
                req0_ready = !req1_valid || !rr_q;
                req1_ready = !req0_valid ||  rr_q;
            end
        end
    end

    assign acc0      = req0_valid && req0_ready;
    assign acc1      = req1_valid && req1_ready;
    assign wr_idx1   = wr_ptr_q + PW'(acc0);
    assign upd_en    = (count_q != '0) && !flush;
    assign upd_pc    = pc_q[rd_ptr_q];
    assign upd_taken = taken_q[rd_ptr_q];
    assign count     = count_q;

    always_comb begin
        pend_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (vld_q[i] && (pc_q[i][INDEX_BITS+1:2] == lookup_pc[INDEX_BITS+1:2]))
                pend_hit = 1'b1;
        if (count_q == '0)
            pend_hit = 1'b0;
    end

    always_comb begin
        pc_d     = pc_q;
        taken_d  = taken_q;
        vld_d    = vld_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        rr_d     = rr_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++)
                vld_d[i] = 1'b0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pop first so a same-slot enqueue after wrap still lands valid.
            if (upd_en) begin
                vld_d[rd_ptr_q] = 1'b0;
                rd_ptr_d        = rd_ptr_q + PW'(1);
            end
            if (acc0) begin
                pc_d[wr_ptr_q]    = req0_pc;
                taken_d[wr_ptr_q] = req0_taken;
                vld_d[wr_ptr_q]   = 1'b1;
            end
            if (acc1) begin
                pc_d[wr_idx1]    = req1_pc;
                taken_d[wr_idx1] = req1_taken;
                vld_d[wr_idx1]   = 1'b1;
            end
            wr_ptr_d = wr_ptr_q + PW'(acc0) + PW'(acc1);
            count_d  = count_q + CW'(acc0) + CW'(acc1) - CW'(upd_en);
            if ((free == CW'(1)) && req0_valid && req1_valid && (acc0 || acc1))
                rr_d = !rr_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                taken_q[i] <= 1'b0;
                vld_q[i]   <= 1'b0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            rr_q     <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            taken_q  <= taken_d;
            vld_q    <= vld_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            rr_q     <= rr_d;
        end
    end
endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed bench for bp_update_scheduler: drain order, arbitration, wrap,
// flush, pending-index detection and asynchronous reset.
module tb_bp_update_scheduler;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 0, req0_taken = 0, req1_valid = 0, req1_taken = 0;
    logic [31:0] req0_pc = 0, req1_pc = 0, lookup_pc = 0;
    logic        flush = 0;
    logic        req0_ready, req1_ready, upd_en, upd_taken, pend_hit;
    logic [31:0] upd_pc;
    logic [2:0]  count;

    int n_vec = 0;
    int n_err = 0;

    bp_update_scheduler #(.INDEX_BITS(10), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_pc(req0_pc), .req0_taken(req0_taken),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_pc(req1_pc), .req1_taken(req1_taken),
        .flush(flush), .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .lookup_pc(lookup_pc), .pend_hit(pend_hit), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [31:0] p0, input logic t0,
                         input logic v1, input logic [31:0] p1, input logic t1);
        req0_valid = v0; req0_pc = p0; req0_taken = t0;
        req1_valid = v1; req1_pc = p1; req1_taken = t1;
    endtask

    // Advance to the next falling edge, apply inputs there, settle 1 time unit.
    task automatic step(input logic v0, input logic [31:0] p0, input logic t0,
                        input logic v1, input logic [31:0] p1, input logic t1);
        @(negedge clk);
        drive(v0, p0, t0, v1, p1, t1);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_upd_en", 32'(upd_en), 0);
        chk("rst_pend_hit", 32'(pend_hit), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_rdy0", 32'(req0_ready), 1);
        chk("rst_rdy1", 32'(req1_ready), 1);
        @(negedge clk); reset = 1'b0;

        // single push
        step(1, 32'h100, 1, 0, 0, 0);
        chk("s1_rdy0", 32'(req0_ready), 1);
        chk("s1_upd_en_pre", 32'(upd_en), 0);
        step(0, 0, 0, 0, 0, 0);
        chk("s1_upd_en", 32'(upd_en), 1);
        chk("s1_upd_pc", upd_pc, 32'h100);
        chk("s1_upd_taken", 32'(upd_taken), 1);
        chk("s1_count", 32'(count), 1);
        // dual push, drained in slot order
        step(1, 32'h200, 0, 1, 32'h204, 1);
        chk("s1_upd_en_post", 32'(upd_en), 0);
        chk("s1_count_post", 32'(count), 0);
        step(0, 0, 0, 0, 0, 0);
        chk("d_pc0", upd_pc, 32'h200);
        chk("d_tk0", 32'(upd_taken), 0);
        chk("d_count", 32'(count), 2);
        step(0, 0, 0, 0, 0, 0);
        chk("d_pc1", upd_pc, 32'h204);
        chk("d_tk1", 32'(upd_taken), 1);
        // fill to count 3, wrap wr_ptr, round-robin
        step(1, 32'h300, 0, 1, 32'h304, 0);
        chk("d_empty", 32'(upd_en), 0);
        chk("f_rdy1_free4", 32'(req1_ready), 1);
        step(1, 32'h308, 1, 1, 32'h30C, 0);
        chk("f_rdy0_free2", 32'(req0_ready), 1);
        chk("f_rdy1_free2", 32'(req1_ready), 1);
        chk("f_pc300", upd_pc, 32'h300);
        step(1, 32'h310, 1, 1, 32'h314, 1);
        chk("f_count3", 32'(count), 3);
        chk("rr0_rdy0", 32'(req0_ready), 1);
        chk("rr0_rdy1", 32'(req1_ready), 0);
        chk("f_pc304", upd_pc, 32'h304);
        step(1, 32'h318, 0, 1, 32'h314, 1);
        chk("rr1_rdy0", 32'(req0_ready), 0);
        chk("rr1_rdy1", 32'(req1_ready), 1);
        chk("f_pc308", upd_pc, 32'h308);
        step(0, 0, 0, 1, 32'h318, 0);
        chk("solo_rdy1", 32'(req1_ready), 1);
        chk("f_pc30c", upd_pc, 32'h30C);
        chk("f_count3b", 32'(count), 3);
        step(0, 0, 0, 0, 0, 0);
        chk("w_pc310", upd_pc, 32'h310);
        step(0, 0, 0, 0, 0, 0);
        chk("w_pc314", upd_pc, 32'h314);
        chk("w_count2", 32'(count), 2);
        step(0, 0, 0, 0, 0, 0);
        chk("w_pc318", upd_pc, 32'h318);
        chk("w_tk318", 32'(upd_taken), 0);
        // queue three, then flush
        step(1, 32'h400, 1, 1, 32'h404, 1);
        chk("w_empty", 32'(upd_en), 0);
        chk("w_count0", 32'(count), 0);
        step(1, 32'h408, 1, 1, 32'h40C, 1);
        chk("q_pc400", upd_pc, 32'h400);
        step(1, 32'h500, 1, 0, 0, 0);
        flush = 1'b1; #1;
        chk("fl_count3", 32'(count), 3);
        chk("fl_upd_en", 32'(upd_en), 0);
        chk("fl_rdy0", 32'(req0_ready), 0);
        chk("fl_rdy1", 32'(req1_ready), 0);
        step(0, 0, 0, 0, 0, 0);
        flush = 1'b0; lookup_pc = 32'h404; #1;
        chk("pf_count", 32'(count), 0);
        chk("pf_upd_en", 32'(upd_en), 0);
        chk("pf_pend", 32'(pend_hit), 0);
        // pending-index detection
        step(1, 32'h1004, 1, 0, 0, 0);
        lookup_pc = 32'h0004; #1;
        chk("pf_upd_en2", 32'(upd_en), 0);
        step(0, 0, 0, 0, 0, 0);
        chk("ph_upd_pc", upd_pc, 32'h1004);
        chk("ph_hit", 32'(pend_hit), 1);
        lookup_pc = 32'h0008; #1;
        chk("ph_miss", 32'(pend_hit), 0);
        step(0, 0, 0, 0, 0, 0);
        lookup_pc = 32'h0004; #1;
        chk("ph_drained", 32'(pend_hit), 0);
        chk("ph_count0", 32'(count), 0);
        // asynchronous reset with entries queued
        step(1, 32'h600, 1, 1, 32'h604, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("ar_count_pre", 32'(count), 2);
        reset = 1'b1; #1;
        chk("ar_count", 32'(count), 0);
        chk("ar_upd_en", 32'(upd_en), 0);
        chk("ar_rdy1", 32'(req1_ready), 1);
        @(negedge clk); reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
